// File: rtl/cpu_reg_pkg.sv
// Shared types and defaults for the cpu_* register-bank responder.
package cpu_reg_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam int IDX_ID     = 0;
   localparam int IDX_STATUS = 1;

   localparam logic [31:0] ID_VALUE_DEF      = 32'hC0DE_0001;
   localparam logic [31:0] DEFAULT_RDATA_DEF = 32'hDEAD_BEEF;

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cpu_reg_responder.sv
// Register-bank target for the cpu_* request/response handshake: one access at a time,
// fixed wait latency, ID/status read-only words followed by read-write registers.
module cpu_reg_responder
   import cpu_reg_pkg::*;
#(
   parameter int                ADDR_WIDTH    = 32,
   parameter int                DATA_WIDTH    = 32,
   parameter int                NUM_REGS      = 8,
   parameter int                ADDR_LSB      = 2,
   parameter int                WAIT_CYCLES   = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE      = ID_VALUE_DEF,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = DEFAULT_RDATA_DEF
) (
   input  logic                           cpu_s_clk,
   input  logic                           cpu_s_reset,
   input  logic                           cpu_s_write,
   input  logic                           cpu_s_read,
   input  logic [ADDR_WIDTH-1:0]          cpu_s_address,
   input  logic [DATA_WIDTH-1:0]          cpu_s_write_data,
   output logic [DATA_WIDTH-1:0]          cpu_s_read_data,
   output logic                           cpu_s_access_ready,
   output logic                           cpu_s_access_complete,
   input  logic [DATA_WIDTH-1:0]          status_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int          IDX_W    = idx_width(NUM_REGS);
   localparam int          HI_W     = ADDR_WIDTH - ADDR_LSB - IDX_W;
   localparam int          NUM_RW   = NUM_REGS - 2;
   localparam logic [7:0]  WAIT_CNT = 8'(WAIT_CYCLES);

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    is_write_q, is_write_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    in_range_q, in_range_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    ready_q, ready_d;
   logic                    complete_q, complete_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
   logic [DATA_WIDTH-1:0]   rw_q [NUM_RW];
   logic [DATA_WIDTH-1:0]   rw_d [NUM_RW];

   logic [IDX_W-1:0]        idx_s;
   logic                    in_range_s;
   logic [IDX_W-1:0]        rw_idx_s;
   logic                    is_rw_s;
   logic [DATA_WIDTH-1:0]   read_mux_s;
   logic                    unused_addr_s;

   assign idx_s         = cpu_s_address[ADDR_LSB +: IDX_W];
   assign in_range_s    = (cpu_s_address[ADDR_WIDTH-1 -: HI_W] == '0) && (int'(idx_s) < NUM_REGS);
   assign rw_idx_s      = idx_q - IDX_W'(2);
   assign is_rw_s       = in_range_q && (int'(idx_q) >= 2);
   assign unused_addr_s = ^cpu_s_address[ADDR_LSB-1:0];

   // Read data selection for the captured index; status is sampled at completion.
   always_comb begin
      read_mux_s = DEFAULT_RDATA;
      if (!in_range_q) begin
         read_mux_s = DEFAULT_RDATA;
      end else if (idx_q == IDX_W'(IDX_ID)) begin
         read_mux_s = ID_VALUE;
      end else if (idx_q == IDX_W'(IDX_STATUS)) begin
         read_mux_s = status_in;
      end else begin
         read_mux_s = rw_q[rw_idx_s];
      end
   end

   // FSM next state, request capture and access execution.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_write_d = is_write_q;
      idx_d      = idx_q;
      in_range_d = in_range_q;
      wdata_d    = wdata_q;
      ready_d    = 1'b0;
      complete_d = 1'b0;
      rdata_d    = rdata_q;
      wr_pulse_d = '0;
      rw_d       = rw_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_s_write || cpu_s_read) begin
               state_d    = ST_WAIT;
               cnt_d      = WAIT_CNT;
               is_write_d = cpu_s_write;
               idx_d      = idx_s;
               in_range_d = in_range_s;
               wdata_d    = cpu_s_write_data;
               ready_d    = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d    = ST_IDLE;
               complete_d = 1'b1;
               if (is_write_q) begin
                  // Writes to ID/status or outside the bank are silently dropped.
                  if (is_rw_s) begin
                     rw_d[rw_idx_s]    = wdata_q;
                     wr_pulse_d[idx_q] = 1'b1;
                  end else begin
                     wr_pulse_d = '0;
                  end
               end else begin
                  rdata_d = read_mux_s;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and register bank, synchronously reset.
   always_ff @(posedge cpu_s_clk) begin
      if (cpu_s_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         is_write_q <= 1'b0;
         idx_q      <= '0;
         in_range_q <= 1'b0;
         wdata_q    <= '0;
         ready_q    <= 1'b0;
         complete_q <= 1'b0;
         rdata_q    <= '0;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_RW; i++) begin
            rw_q[i] <= RESET_VALUE;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_write_q <= is_write_d;
         idx_q      <= idx_d;
         in_range_q <= in_range_d;
         wdata_q    <= wdata_d;
         ready_q    <= ready_d;
         complete_q <= complete_d;
         rdata_q    <= rdata_d;
         wr_pulse_q <= wr_pulse_d;
         for (int i = 0; i < NUM_RW; i++) begin
            rw_q[i] <= rw_d[i];
         end
      end
   end

   // Flatten the bank onto reg_q; read-only slots read as zero.
   always_comb begin
      reg_q = '0;
      for (int i = 2; i < NUM_REGS; i++) begin
         reg_q[i*DATA_WIDTH +: DATA_WIDTH] = rw_q[i-2];
      end
   end

   assign cpu_s_read_data       = rdata_q;
   assign cpu_s_access_ready    = ready_q;
   assign cpu_s_access_complete = complete_q;
   assign reg_wr_pulse          = wr_pulse_q;

endmodule
